// File: rtl/sb_stream_arbiter.sv
// rtl/sb_stream_arbiter.sv - packet-aware round-robin arbiter onto one registered stream
module sb_stream_arbiter #(
   parameter int N  = 2,
   parameter int DW = 416
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N*DW-1:0] in_data,
   input  logic [N*32-1:0] in_dest,
   input  logic [N-1:0]    in_last,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   output logic [DW-1:0]   out_data,
   output logic [31:0]     out_dest,
   output logic            out_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    grant,
   output logic            locked
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [DW-1:0] r_out_data;
   logic [31:0]   r_out_dest;
   logic          r_out_last;
   logic          r_out_valid;
   logic          r_lock;
   logic [IW-1:0] r_lock_idx;
   logic [IW-1:0] r_ptr;

   logic          w_load;
   logic          w_sel_vld;
   logic [IW-1:0] w_sel_idx;
   logic [IW-1:0] w_cand;
   logic [N-1:0]  w_sel_onehot;
   logic          w_accept;
   logic          w_sel_last;
   logic [IW-1:0] w_ptr_next;

   assign w_load = !r_out_valid || out_ready;

   // Descending scan so the candidate closest to r_ptr is written last and wins.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_idx = '0;
      w_cand    = '0;
      if (r_lock) begin
         w_sel_vld = 1'b1;
         w_sel_idx = r_lock_idx;
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            w_cand = IW'((int'(r_ptr) + k) % N);
            if (in_valid[w_cand]) begin
               w_sel_vld = 1'b1;
               w_sel_idx = w_cand;
            end
         end
      end
   end

   assign w_sel_onehot = w_sel_vld ? (N'(1) << w_sel_idx) : '0;
   assign w_sel_last   = in_last[w_sel_idx];
   assign w_accept     = w_sel_vld && w_load && in_valid[w_sel_idx];
   assign w_ptr_next   = (w_sel_idx == IW'(N - 1)) ? '0 : w_sel_idx + 1'b1;

   assign in_ready = w_load ? w_sel_onehot : '0;
   assign grant    = w_sel_onehot;
   assign locked   = r_lock;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_dest  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
         r_lock      <= 1'b0;
         r_lock_idx  <= '0;
         r_ptr       <= '0;
      end else if (w_accept) begin
         r_out_data  <= in_data[w_sel_idx*DW +: DW];
         r_out_dest  <= in_dest[w_sel_idx*32 +: 32];
         r_out_last  <= w_sel_last;
         r_out_valid <= 1'b1;
         if (w_sel_last) begin
            r_lock <= 1'b0;
            r_ptr  <= w_ptr_next;
         end else begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_sel_idx;
         end
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_dest  = r_out_dest;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sb_stream_arbiter.sv
// tb/tb_sb_stream_arbiter.sv - directed bench for sb_stream_arbiter at N=2 and N=4
module tb_sb_stream_arbiter;

   localparam int DW = 416;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic            reset2, reset4;
   logic [2*DW-1:0] d2_data;
   logic [2*32-1:0] d2_dest;
   logic [1:0]      d2_last, d2_valid, d2_ready, d2_grant;
   logic [DW-1:0]   d2_out_data;
   logic [31:0]     d2_out_dest;
   logic            d2_out_last, d2_out_valid, d2_out_ready, d2_locked;

   logic [4*DW-1:0] d4_data;
   logic [4*32-1:0] d4_dest;
   logic [3:0]      d4_last, d4_valid, d4_ready, d4_grant;
   logic [DW-1:0]   d4_out_data;
   logic [31:0]     d4_out_dest;
   logic            d4_out_last, d4_out_valid, d4_out_ready, d4_locked;

   sb_stream_arbiter #(.N(2), .DW(DW)) u_dut2 (
      .clk(clk), .reset(reset2),
      .in_data(d2_data), .in_dest(d2_dest), .in_last(d2_last),
      .in_valid(d2_valid), .in_ready(d2_ready),
      .out_data(d2_out_data), .out_dest(d2_out_dest), .out_last(d2_out_last),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready),
      .grant(d2_grant), .locked(d2_locked)
   );

   sb_stream_arbiter #(.N(4), .DW(DW)) u_dut4 (
      .clk(clk), .reset(reset4),
      .in_data(d4_data), .in_dest(d4_dest), .in_last(d4_last),
      .in_valid(d4_valid), .in_ready(d4_ready),
      .out_data(d4_out_data), .out_dest(d4_out_dest), .out_last(d4_out_last),
      .out_valid(d4_out_valid), .out_ready(d4_out_ready),
      .grant(d4_grant), .locked(d4_locked)
   );

   task automatic check(input string tag, input logic [447:0] got, input logic [447:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkd(input int s, input int b);
      logic [DW-1:0] r;
      r = '0;
      r[15:0] = 16'(s * 256 + b);
      return r;
   endfunction

   function automatic logic [31:0] mkdest(input int s);
      return 32'hD000_0000 | 32'(s);
   endfunction

   task automatic drive2(input int s, input int b, input logic last);
      d2_data[s*DW +: DW] = mkd(s, b);
      d2_dest[s*32 +: 32] = mkdest(s);
      d2_last[s]          = last;
   endtask

   task automatic drive4(input int s, input int b, input logic last);
      d4_data[s*DW +: DW] = mkd(s, b);
      d4_dest[s*32 +: 32] = mkdest(s);
      d4_last[s]          = last;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset2 = 1'b1; reset4 = 1'b1;
      d2_data = '0; d2_dest = '0; d2_last = '0; d2_valid = '0; d2_out_ready = 1'b1;
      d4_data = '0; d4_dest = '0; d4_last = '0; d4_valid = '0; d4_out_ready = 1'b1;
      tick(); tick();
      check("rst_valid", d2_out_valid, 0);
      check("rst_locked", d2_locked, 0);
      check("rst_grant", d2_grant, 0);
      check("rst_data", d2_out_data, 0);
      check("rst_dest", d2_out_dest, 0);
      check("rst_last", d2_out_last, 0);
      check("rst4_valid", d4_out_valid, 0);
      reset2 = 1'b0; reset4 = 1'b0;

      // Both streams valid with single-beat packets: strict alternation.
      drive2(0, 0, 1'b1); drive2(1, 0, 1'b1); d2_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1 check("t1_grant", d2_grant, (k % 2) ? 2'b10 : 2'b01);
         tick();
         check("t1_data", d2_out_data, mkd(k % 2, 0));
         check("t1_dest", d2_out_dest, mkdest(k % 2));
         check("t1_valid", d2_out_valid, 1);
      end
      d2_valid = 2'b00;
      tick();
      check("t1_drain", d2_out_valid, 0);

      // Three-beat packet on stream 0 holds off stream 1.
      drive2(0, 0, 1'b0); drive2(1, 0, 1'b1); d2_valid = 2'b11;
      for (int b = 0; b < 3; b++) begin
         drive2(0, b, b == 2);
         #1 check("t2_ready", d2_ready, 2'b01);
         tick();
         check("t2_data", d2_out_data, mkd(0, b));
         check("t2_last", d2_out_last, b == 2);
         check("t2_locked", d2_locked, b != 2);
      end
      d2_valid = 2'b10;
      #1 check("t2_grant1", d2_grant, 2'b10);
      tick();
      check("t2_s1", d2_out_data, mkd(1, 0));
      d2_valid = 2'b00;
      tick();

      // Bubble inside a locked packet.
      drive2(0, 0, 1'b0); drive2(1, 1, 1'b1); d2_valid = 2'b11;
      tick();
      check("t3_b0", d2_out_data, mkd(0, 0));
      check("t3_lock0", d2_locked, 1);
      d2_valid = 2'b10;
      for (int k = 0; k < 2; k++) begin
         #1 check("t3_grant", d2_grant, 2'b01);
         check("t3_ready", d2_ready, 2'b01);
         tick();
         check("t3_bubble_valid", d2_out_valid, 0);
         check("t3_bubble_lock", d2_locked, 1);
      end
      drive2(0, 1, 1'b1); d2_valid = 2'b11;
      tick();
      check("t3_b1", d2_out_data, mkd(0, 1));
      check("t3_b1_valid", d2_out_valid, 1);
      check("t3_unlock", d2_locked, 0);
      tick();
      check("t3_s1", d2_out_data, mkd(1, 1));
      d2_valid = 2'b00;
      tick();

      // Downstream stall freezes the output register.
      d2_data[0 +: DW] = {52{8'hA5}}; d2_dest[0 +: 32] = 32'hA5A5_A5A5; d2_last[0] = 1'b1;
      d2_valid = 2'b01;
      tick();
      check("t4_first", d2_out_data, {52{8'hA5}});
      d2_out_ready = 1'b0;
      d2_data[0 +: DW] = {52{8'h5A}}; d2_dest[0 +: 32] = 32'h5A5A_5A5A;
      for (int k = 0; k < 4; k++) begin
         #1 check("t4_ready0", d2_ready, 2'b00);
         check("t4_hold_data", d2_out_data, {52{8'hA5}});
         check("t4_hold_dest", d2_out_dest, 32'hA5A5_A5A5);
         check("t4_hold_last", d2_out_last, 1);
         check("t4_hold_valid", d2_out_valid, 1);
         tick();
      end
      d2_out_ready = 1'b1;
      #1 check("t4_ready1", d2_ready, 2'b01);
      tick();
      check("t4_next", d2_out_data, {52{8'h5A}});
      check("t4_next_dest", d2_out_dest, 32'h5A5A_5A5A);
      d2_valid = 2'b00;
      tick();
      check("t4_nodup", d2_out_valid, 0);

      // N=4: move ptr to 2, then streams 1 and 3 alternate and wrap.
      drive4(1, 0, 1'b1); d4_valid = 4'b0010;
      tick();
      check("t5_pre", d4_out_data, mkd(1, 0));
      drive4(3, 0, 1'b1); d4_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1 check("t5_grant", d4_grant, (k % 2) ? 4'b0010 : 4'b1000);
         tick();
         check("t5_data", d4_out_data, mkd((k % 2) ? 1 : 3, 0));
      end
      tick();
      check("t5_s3", d4_out_data, mkd(3, 0));
      drive4(0, 0, 1'b1); d4_valid = 4'b1011;
      #1 check("t5_wrap", d4_grant, 4'b0001);
      tick();
      check("t5_wrap_data", d4_out_data, mkd(0, 0));
      d4_valid = 4'b0000;
      tick();

      // Async reset while stream 2 is mid-packet.
      drive4(2, 0, 1'b0); d4_valid = 4'b0100;
      tick();
      check("t6_locked", d4_locked, 1);
      check("t6_data", d4_out_data, mkd(2, 0));
      drive4(0, 0, 1'b1); drive4(1, 0, 1'b1); drive4(2, 1, 1'b1); d4_valid = 4'b0111;
      #1 reset4 = 1'b1;
      #1 check("t6_rst_valid", d4_out_valid, 0);
      check("t6_rst_locked", d4_locked, 0);
      #1 reset4 = 1'b0;
      #1 check("t6_grant", d4_grant, 4'b0001);
      tick();
      check("t6_first", d4_out_data, mkd(0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sb_stream_arbiter.md
Name: sb_stream_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares one switchboard-style stream between N requesters.
- Each stream carries data, dest, last, valid and ready. Output feeds a single queue/bridge endpoint (e.g. an SB transmit port).
- Grant is held from the first beat of a packet until its `last` beat. Packets from different requesters are never interleaved.
- Output is registered and sustains one beat per cycle under continuous ready.

Parameters:
- N, 2, number of requester streams (1..16).
- DW, 416, data width per stream (32b cmd + 64b src + 64b dst + 256b payload).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N*DW  requester data, stream i at bits [i*DW +: DW].
- in_dest  input  N*32  requester destination, stream i at bits [i*32 +: 32].
- in_last  input  N  per-stream end-of-packet flag.
- in_valid  input  N  per-stream valid.
- in_ready  output  N  per-stream ready.
- out_data  output  DW  registered output data.
- out_dest  output  32  registered output destination.
- out_last  output  1  registered end-of-packet.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- grant  output  N  one-hot index of the stream currently selected (0 when none).
- locked  output  1  high while a packet is in progress (first beat taken, last not yet taken).

Behaviour:
- Reset (async assert, sync-safe release):
  - out_valid=0, out_data=0, out_dest=0, out_last=0.
  - Internal lock flag=0, lock index=0, round-robin pointer=0.
- Load condition: `load = !out_valid || out_ready`. The output register accepts a new beat only when load=1.
- Selection (combinational, `sel`):
  - Locked: sel = lock index, regardless of other valids.
  - Unlocked: sel = first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N). No valid input means no selection.
- Outputs derived from selection:
  - grant = one-hot(sel) when a selection exists, else 0.
  - locked = lock flag.
- in_ready[i] = load && (i==sel) && selection exists.
  - All non-selected in_ready are 0.
  - in_ready depends combinationally on out_ready and in_valid. It must not depend on in_ready itself.
- Input handshake: beat accepted on a cycle with in_valid[sel] && in_ready[sel]. That edge does:
  - out_data/out_dest/out_last <= stream sel fields; out_valid <= 1.
  - If last=0: lock flag <= 1, lock index <= sel.
  - If last=1: lock flag <= 0, ptr <= (sel+1) mod N. A single-beat packet never sets lock.
- Output draining: if out_valid && out_ready and no beat is accepted, out_valid <= 0. Data, dest and last hold their values.
- Output stability: while out_valid && !out_ready, the out_* registers are frozen and in_ready is all 0.
- Latency and throughput:
  - One cycle from input acceptance to out_valid.
  - Full throughput (one beat per cycle) while out_ready=1, including back-to-back packets from different requesters. There is no idle cycle at grant change.
- Locked requester with in_valid low (bubble): in_ready stays low for all others. Grant and lock are held and no beat is emitted. Lock is never released without a last beat.
- Wrap-around: ptr after granting N-1 is 0.
- N=1: behaves as a one-stage register slice. Ptr stays 0.
- Reset mid-packet: lock is dropped and ptr=0. Any partially forwarded packet is truncated. Upstream must also be reset.
- Fairness: with all N requesters continuously valid with single-beat packets, grants rotate 0,1,…,N-1,0,…

Test Plan:
- Reset, then drive in_valid=2'b11 with single-beat packets, out_ready=1 -> out stream sources alternate 0,1,0,1. out_valid stays 1 every cycle after the first. grant alternates 01,10.
- Stream 0 sends a 3-beat packet (last on beat 3) while stream 1 is valid throughout -> out shows s0,s0,s0, then s1. locked=1 after beat 1 and 0 after beat 3. in_ready[1]=0 for 3 cycles.
- Stream 0 packet with a 2-cycle in_valid bubble after beat 1, stream 1 valid -> no s1 beat appears before s0 last. out_valid drops for the bubble cycles.
- out_ready held 0 for 4 cycles with out_valid=1 (data=0xA5…) -> out_data, out_dest, out_last stable. in_ready=0. Then out_ready=1 -> next beat appears the following cycle with no loss or duplication.
- N=4, only streams 1 and 3 valid, ptr=2 -> grant order 3,1,3,1. Wrap-around from 3 to 0 is checked via ptr.
- Assert reset while locked mid-packet on stream 2 (N=4) -> out_valid=0 and locked=0 immediately (async). After release, first grant goes to the lowest-index valid stream from ptr=0.
